// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Contents:
//   MEM_BYTES     size of the data memory in bytes
//   WORD_BYTES    bytes per word access
//   port_id_e     requester identity (CPU load/store = 0, DMA/debug = 1)
//   access_legal  word-access legality check (aligned and fully inside DM)
package dm_arb_pkg;

  localparam int unsigned MEM_BYTES  = 128;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_e;

  // The address is compared at full width (zero-extended to 64 bits), so
  // large addresses can never alias back into the memory window.
  function automatic logic access_legal(input logic [63:0] addr,
                                        input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) &&
           (addr <= 64'(mem_bytes - WORD_BYTES));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   req0, req1    request inputs
//   gnt0, gnt1    combinational one-hot grants (both 0 while rst is high)
// The last granted port is remembered; on a conflict the other port wins.
// After reset the DMA port counts as last, so the CPU wins the first conflict.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  port_id_e last_q, last_d;

  // Grants are forced low during reset so nothing downstream can act on a
  // request while the block is being reset.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    last_d = last_q;
    if (!rst) begin
      if (req0 && (!req1 || (last_q == PORT_DMA))) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0) begin
      last_d = PORT_CPU;
    end else if (gnt1) begin
      last_d = PORT_DMA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_DMA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store stage (port 0) and a DMA/debug engine (port 1).
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   pN_req/we/addr/wdata       request payload, held until granted
//   pN_gnt                     combinational grant, access happens this cycle
//   pN_rvalid/rdata/err        registered response one cycle after the grant
//   dm_addr/wdata/write/read   drive to the data memory
//   dm_rdata                   combinational read data from the data memory
// Illegal accesses (misaligned or out of range) are granted but never strobe
// the memory; they return err=1 with zero data.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = dm_arb_pkg::MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p0_err,
  output logic              p1_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_write,
  output logic              dm_read,
  input  logic [DATA_W-1:0] dm_rdata
);

  logic              any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              legal;

  logic              rsp_valid_q, rsp_valid_d;
  port_id_e          rsp_port_q, rsp_port_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (p0_req),
    .req1 (p1_req),
    .gnt0 (p0_gnt),
    .gnt1 (p1_gnt)
  );

  // Winner payload mux, legality check and memory drive. Because the grants
  // are already low during reset, the strobes drop the moment rst rises,
  // which keeps a reset in the middle of a write from committing anything.
  always_comb begin
    any_gnt   = p0_gnt | p1_gnt;
    win_we    = p1_gnt ? p1_we    : p0_we;
    win_addr  = p1_gnt ? p1_addr  : p0_addr;
    win_wdata = p1_gnt ? p1_wdata : p0_wdata;
    legal     = any_gnt && access_legal(64'(win_addr), MEM_BYTES);

    dm_addr   = any_gnt ? win_addr  : '0;
    dm_wdata  = any_gnt ? win_wdata : '0;
    dm_write  = win_we  & legal;
    dm_read   = ~win_we & legal;

    rsp_valid_d = any_gnt;
    rsp_port_d  = p1_gnt ? PORT_DMA : PORT_CPU;
    rsp_err_d   = any_gnt & ~legal;
    rsp_rdata_d = dm_read ? dm_rdata : '0;
  end

  // Response registers: one entry is enough since every access completes in
  // exactly one cycle, so a new grant can overlap the previous response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_CPU;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Only the port that owns the response sees it; the other stays at zero.
  always_comb begin
    p0_rvalid = rsp_valid_q & (rsp_port_q == PORT_CPU);
    p1_rvalid = rsp_valid_q & (rsp_port_q == PORT_DMA);
    p0_rdata  = p0_rvalid ? rsp_rdata_q : '0;
    p1_rdata  = p1_rvalid ? rsp_rdata_q : '0;
    p0_err    = p0_rvalid & rsp_err_q;
    p1_err    = p1_rvalid & rsp_err_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter. A byte-array data memory is attached to
// the DM port; a transaction-level reference model predicts grants, memory
// strobes and responses, and keeps its own copy of memory contents.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_write, dm_read;

  logic [7:0]  env_mem [128];
  logic [7:0]  ref_mem [128];
  logic        preload;

  int          total = 0;
  int          bad   = 0;

  // Reference model state: which port was granted last, and the response
  // expected on the outputs in the current cycle.
  int          m_last;
  bit          e_valid;
  int          e_port;
  logic [31:0] e_rdata;
  bit          e_err;

  dm_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_rdata  (p1_rdata),
    .p0_err    (p0_err),
    .p1_err    (p1_err),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_write  (dm_write),
    .dm_read   (dm_read),
    .dm_rdata  (dm_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initByte(input int i);
    case (i)
      16: return 8'h11;
      17: return 8'h22;
      18: return 8'h33;
      19: return 8'h44;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  // Data memory model: big-endian words, combinational read, write on the
  // rising edge. Preload fills it with a known pattern.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) env_mem[i] <= initByte(i);
    end else if (dm_write && dm_addr <= 32'd124) begin
      env_mem[dm_addr[6:0]]        <= dm_wdata[31:24];
      env_mem[dm_addr[6:0] + 7'd1] <= dm_wdata[23:16];
      env_mem[dm_addr[6:0] + 7'd2] <= dm_wdata[15:8];
      env_mem[dm_addr[6:0] + 7'd3] <= dm_wdata[7:0];
    end
  end

  // Combinational read path of the data memory.
  always_comb begin
    dm_rdata = 32'h0;
    if (dm_addr <= 32'd124) begin
      dm_rdata = {env_mem[dm_addr[6:0]],        env_mem[dm_addr[6:0] + 7'd1],
                  env_mem[dm_addr[6:0] + 7'd2], env_mem[dm_addr[6:0] + 7'd3]};
    end
  end

  function automatic bit legalAddr(input logic [31:0] a);
    return (a % 4 == 0) && (a < 128);
  endfunction

  function automatic logic [31:0] refWord(input int a);
    return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  function automatic logic [31:0] envWord(input int a);
    return {env_mem[a], env_mem[a+1], env_mem[a+2], env_mem[a+3]};
  endfunction

  function automatic logic [31:0] randAddr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7) return 32'($urandom_range(0, 31) * 4);
    if (k == 7) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    if (k == 8) return 32'(128 + $urandom_range(0, 63) * 4);
    return 32'hFFFF_FFFC;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic checkResponse();
    checkOutput("p0_rvalid", p0_rvalid, e_valid && e_port == 0);
    checkOutput("p1_rvalid", p1_rvalid, e_valid && e_port == 1);
    checkOutput("p0_rdata", p0_rdata, (e_valid && e_port == 0) ? e_rdata : 32'h0);
    checkOutput("p1_rdata", p1_rdata, (e_valid && e_port == 1) ? e_rdata : 32'h0);
    checkOutput("p0_err", p0_err, e_valid && e_port == 0 && e_err);
    checkOutput("p1_err", p1_err, e_valid && e_port == 1 && e_err);
  endtask

  // One full cycle: entered 1 time unit after a rising edge, drives the
  // requests, checks grant and memory drive on the falling edge, then checks
  // the response just after the next rising edge.
  task automatic runCycle(input logic r0, input logic w0,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic r1, input logic w1,
                          input logic [31:0] a1, input logic [31:0] d1,
                          output bit g0, output bit g1);
    bit          w, ok, nv, nerr;
    int          np;
    logic [31:0] a, d, nrd;
    applyStimulus(r0, w0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
    g0 = 0; g1 = 0;
    if (r0 && r1) begin
      if (m_last == 1) g0 = 1; else g1 = 1;
    end else if (r0) g0 = 1;
    else if (r1) g1 = 1;
    checkOutput("p0_gnt", p0_gnt, g0);
    checkOutput("p1_gnt", p1_gnt, g1);
    w = 0; ok = 0; a = 0; d = 0;
    nv = 0; np = 0; nerr = 0; nrd = 0;
    if (g0 || g1) begin
      w  = g0 ? w0 : w1;
      a  = g0 ? a0 : a1;
      d  = g0 ? d0 : d1;
      ok = legalAddr(a);
      nv = 1; np = g0 ? 0 : 1; nerr = !ok;
      nrd = (!w && ok) ? refWord(int'(a)) : 32'h0;
    end
    checkOutput("dm_addr", dm_addr, a);
    checkOutput("dm_wdata", dm_wdata, d);
    checkOutput("dm_write", dm_write, w && ok);
    checkOutput("dm_read", dm_read, !w && ok && (g0 || g1));
    @(posedge clk);
    #1;
    if (g0 || g1) begin
      m_last = g0 ? 0 : 1;
      if (w && ok) begin
        for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = d[31 - 8*k -: 8];
      end
    end
    e_valid = nv; e_port = np; e_rdata = nrd; e_err = nerr;
    checkResponse();
  endtask

  initial begin
    bit          g0, g1;
    logic        pr [2];
    logic        pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];

    for (int i = 0; i < 128; i++) ref_mem[i] = initByte(i);
    m_last = 1; e_valid = 0; e_port = 0; e_rdata = 0; e_err = 0;

    // Reset with requests pending: nothing may be granted or strobed.
    rst = 1'b1;
    preload = 1'b1;
    applyStimulus(1, 0, 32'h10, 32'h0, 1, 1, 32'h20, 32'hCAFEF00D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_p0_gnt", p0_gnt, 0);
    checkOutput("rst_p1_gnt", p1_gnt, 0);
    checkOutput("rst_dm_write", dm_write, 0);
    checkOutput("rst_dm_read", dm_read, 0);
    checkResponse();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    preload = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single read");
    runCycle(1, 0, 32'h10, 0, 0, 0, 0, 0, g0, g1);
    checkOutput("single_read", p0_rdata, 32'h11223344);

    $display("[TB] write then read");
    runCycle(0, 0, 0, 0, 1, 1, 32'h7C, 32'hDEADBEEF, g0, g1);
    runCycle(0, 0, 0, 0, 1, 0, 32'h7C, 0, g0, g1);
    checkOutput("wr_rd_data", p1_rdata, 32'hDEADBEEF);
    checkOutput("mem_7c", env_mem[124], 8'hDE);
    checkOutput("mem_7d", env_mem[125], 8'hAD);
    checkOutput("mem_7e", env_mem[126], 8'hBE);
    checkOutput("mem_7f", env_mem[127], 8'hEF);

    $display("[TB] illegal accesses");
    runCycle(1, 1, 32'h7E, 32'h01020304, 0, 0, 0, 0, g0, g1);
    checkOutput("misaligned_err", p0_err, 1);
    runCycle(1, 1, 32'h80, 32'h05060708, 0, 0, 0, 0, g0, g1);
    checkOutput("range_err", p0_err, 1);
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    $display("[TB] random traffic");
    for (int p = 0; p < 2; p++) begin
      pr[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p]) begin
          pr[p] = ($urandom_range(0, 3) != 0);
          pw[p] = $urandom_range(0, 1) == 1;
          pa[p] = randAddr();
          pd[p] = $urandom();
        end
      end
      runCycle(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1], g0, g1);
      if (g0) pr[0] = 0;
      if (g1) pr[1] = 0;
    end

    $display("[TB] reset during write");
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
    #3;
    checkOutput("pre_rst_gnt", p1_gnt, 1);
    checkOutput("pre_rst_write", dm_write, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_write", dm_write, 0);
    checkOutput("mid_rst_gnt", p1_gnt, 0);
    checkOutput("mid_rst_addr", dm_addr, 0);
    e_valid = 0;
    checkResponse();
    @(posedge clk);
    #1;
    checkResponse();
    checkOutput("mem_20_kept", envWord(32), refWord(32));
    m_last = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkResponse();

    $display("[TB] conflict fairness");
    for (int c = 0; c < 8; c++) begin
      runCycle(1, 0, 32'(4 * c), 0, 1, 0, 32'(4 * c + 64), 0, g0, g1);
    end
    runCycle(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);

    for (int i = 0; i < 128; i += 4) begin
      checkOutput("mem_final", envWord(i), refWord(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester, round-robin arbiter that shares the single-port byte-addressed data memory (`DM`, 128 bytes, big-endian word layout) between the CPU load/store stage (port 0) and a DMA/debug engine (port 1). It grants at most one access per cycle, drives the DM address, write-data and read/write strobes, and returns registered read data with a one-cycle latency. It also rejects misaligned or out-of-range accesses without touching memory.

## Interface
- `ADDR_W`, default 32: address width of both requesters and DM.
- `DATA_W`, default 32: word width; fixed at 4 bytes.
- `MEM_BYTES`, default 128: DM size in bytes; must match `DATA_MEM_SIZE`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  access request; held with its payload until granted.
- `p0_we`, `p1_we`  in  1  1 = word write, 0 = word read.
- `p0_addr`, `p1_addr`  in  ADDR_W  byte address.
- `p0_wdata`, `p1_wdata`  in  DATA_W  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; the access is performed this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  response pulse, one cycle after the grant; asserted for both reads and writes.
- `p0_rdata`, `p1_rdata`  out  DATA_W  registered read data; 0 for writes and errors.
- `p0_err`, `p1_err`  out  1  qualified by `rvalid`; access rejected.
- `dm_addr`  out  ADDR_W  to DM `MemAddr`.
- `dm_wdata`  out  DATA_W  to DM `MemWriteData`.
- `dm_write`  out  1  to DM `MemWrite`.
- `dm_read`  out  1  to DM `MemRead`.
- `dm_rdata`  in  DATA_W  from DM `MemReadData`; combinational.

## Operation
**Arbitration**
- Register `last` records the last granted port; reset value is 1, so port 0 wins the first conflict.
- Only one port requesting: that port is granted.
- Both ports requesting: the port ≠ `last` is granted.
- `last` updates only on a grant.

**Legality check** (on the granted payload, full ADDR_W compare)
- Legal when `addr[1:0]==0` and `addr <= MEM_BYTES-4`.
- Illegal: `dm_read` and `dm_write` are held at 0, and the response carries `err=1` with `rdata=0`.

**DM drive in the grant cycle**
- `dm_addr` and `dm_wdata` are taken from the winner.
- `dm_write = we & legal`.
- `dm_read = ~we & legal`.
- With no grant, `dm_addr` and `dm_wdata` are 0 and both strobes are 0.

**Response registers**
- At the grant-cycle edge, capture:
  - the port id;
  - `rdata` (`dm_rdata` for a legal read, else 0);
  - `err`;
  - a `valid` bit.
- In the following cycle, only that port's `rvalid` is high. The other port's `rdata` and `err` are 0.

**Boundary rules**
- The requester drops `req` after `gnt` or issues a new request. Back-to-back grants to the same port are allowed every cycle when the other port is idle.
- A new grant may coincide with `rvalid` of the previous access; this is fully pipelined.
- A read that follows a write to the same address in the next cycle returns the new data.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from `req` and `last`.
- Read latency: data appears with `rvalid` exactly 1 cycle after `gnt`.
- Write commit: DM is updated at the rising edge that ends the grant cycle.
- Throughput is 1 access per cycle. The worst-case wait for a continuously requesting port is 1 cycle.
- While `rst` is asserted:
  - all `gnt`, `rvalid`, `err`, `dm_write`, `dm_read` are 0;
  - `rdata` is 0 and `last` is 1.
- Reset asserted during a grant cycle suppresses the write immediately; no partial commit is allowed.
- The first grant can occur in the first cycle after `rst` deasserts.

## Structure
- Shared package `dm_arb_pkg` holds:
  - `MEM_BYTES`;
  - the word-size constant (4);
  - the port-id typedef (`PORT_CPU=0`, `PORT_DMA=1`);
  - the legality-check function.
- Sub-module `rr_arb2` is a two-way round-robin arbiter: request inputs, grant outputs, `last` register with async reset.
- The top level contains the payload mux, the legality check and the response registers.

## Test plan
- **Single read:** preload DM[0x10..0x13]=11 22 33 44, p0 reads 0x10 → `p0_gnt` in the same cycle; next cycle `p0_rvalid=1`, `p0_rdata=0x11223344`, `p0_err=0`.
- **Conflict fairness:** both ports request reads continuously from reset → grants alternate p0, p1, p0, p1; each `rvalid` targets the matching port.
- **Write then read:** p1 writes 0xDEADBEEF to 0x7C, then reads 0x7C the next cycle → `rdata=0xDEADBEEF`; DM bytes 0x7C..0x7F = DE AD BE EF.
- **Illegal access:** p0 writes to 0x7E (misaligned), then to 0x80 (out of range) → `gnt=1`, `dm_write=0`, `rvalid=1` with `err=1`; memory unchanged.
- **Reset mid-write:** assert `rst` while p1 is granted a write of 0x12345678 to 0x20 → `dm_write` drops immediately, DM[0x20] is unchanged, and all outputs are 0; after release, p0 wins the first conflict.
